bin2bcd_seq: RTL and testbench
==============================

# bin2bcd_seq

Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) method, one bit per clock. It sits upstream of the per-digit BCD-to-seven-segment decoders. It turns binary game values (current board slot, move counters, scores) into packed BCD digits. Each 4-bit digit of its output drives one decoder instance directly. A start/done handshake lets control logic request a new conversion whenever the displayed value changes.

## Interface
- BIN_W, default 8: width of the binary input; must be ≥ 1.
- DIGITS, default 3: number of BCD digits produced; must be ≥ 1.
- clk  input  1: single clock; all state updates on the rising edge.
- rst  input  1: asynchronous, active-high reset.
- start  input  1: conversion request, sampled only while idle.
- bin  input  BIN_W: binary value, sampled on the accepted start edge.
- busy  output  1: high while a conversion is in progress.
- done  output  1: one-cycle pulse when `bcd` and `overflow` update.
- bcd  output  4*DIGITS: packed result; digit i is bcd[4i+3:4i], with digit 0 the least significant.
- overflow  output  1: the last result did not fit in DIGITS digits.

## Operation
- States:
  - IDLE: busy=0.
  - SHIFT: busy=1.
- IDLE, start=1 at edge k:
  - latch bin into the shift register;
  - clear the BCD scratch register (4*DIGITS bits) and the overflow flag;
  - load the counter with BIN_W;
  - go to SHIFT.
- SHIFT, once per edge:
  - correct every scratch digit ≥5 by adding 3 (4-bit, no carry between digits);
  - shift {scratch, shift register} left by 1;
  - any 1 shifted out of the top digit sets the sticky overflow flag;
  - decrement the counter.
- At the edge where the counter goes 1→0, the final shifted value (not the previous one) is loaded into `bcd`, overflow is loaded into `overflow`, done is set to 1 for one cycle, and the state returns to IDLE.
- start while busy=1 is ignored. It is not queued.
- start in the cycle done=1 is accepted, because the block is already IDLE. This gives back-to-back conversions.
- `bcd` and `overflow` hold their values between completions.
- Counter width is $clog2(BIN_W+1).
- Overflow case: `bcd` holds the low DIGITS digits of the true value.

## Timing
- Latency: start sampled at edge k → done=1 and new bcd valid after edge k+BIN_W.
- busy is high from edge k+1 through edge k+BIN_W.
- Throughput: one conversion every BIN_W cycles.
- Reset values, async and immediate:
  - state IDLE, busy 0, done 0, overflow 0;
  - bcd = display-zero pattern (see Configuration);
  - scratch and counter cleared.
- Reset mid-conversion: the conversion is aborted with no done pulse, and outputs return to their reset values.
- BIN_W=1: a single SHIFT cycle, so done follows start after one cycle.

## Configuration
- Macro `BIN2BCD_BLANK_EN` controls leading-zero blanking.
- Defined:
  - when `bcd` is loaded, every leading zero digit above digit 0 is replaced with 4'hF, which the segment decoder renders as all-off;
  - digit 0 is never blanked;
  - reset value of bcd is 4'hF in all digits except digit 0, which is 4'h0.
- Undefined:
  - digits are loaded unmodified;
  - reset value of bcd is all zeros.
- Blanking does not affect `overflow`.

## Structure
- Package `bin2bcd_pkg`:
  - state enum {IDLE, SHIFT};
  - BCD_BLANK = 4'hF;
  - BCD_DIGIT_W = 4.
- Sub-module `bcd_add3`: combinational 4-bit digit correction (≥5 → +3). It is instantiated DIGITS times in a generate loop.
- Top level holds the FSM, counter, shift and scratch registers, and output registers.

## Test plan
- Defaults (BIN_W=8, DIGITS=3), blanking off:
  - bin=0, start pulse → done exactly 8 cycles later, bcd=12'h000, overflow=0.
  - bin=255 → bcd=12'h255, overflow=0.
  - bin=42 → bcd=12'h042.
- Same as above with `BIN2BCD_BLANK_EN` defined:
  - bin=42 → bcd=12'hF42;
  - bin=0 → bcd=12'hFF0;
  - after reset, bcd=12'hFF0.
- Back-to-back and ignored starts:
  - start bin=7, then assert start with bin=99 during cycles 2–5 → those starts are ignored and the first done gives 12'h007;
  - start bin=99 in the done cycle → second done 8 cycles later with 12'h099.
- Reset mid-conversion: assert rst at cycle 4 of a conversion → busy=0 and done=0 immediately, bcd is at its reset value, and no done pulse follows.
- Overflow, DIGITS=2, BIN_W=8:
  - bin=100 → overflow=1, bcd=8'h00;
  - bin=99 → overflow=0, bcd=8'h99.
- BIN_W=1, DIGITS=1: bin=1 → done 1 cycle after start, bcd=4'h1.

Source files
------------

// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int         BCD_DIGIT_W = 4;
  localparam logic [3:0] BCD_BLANK   = 4'hF;

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Start/done handshake and result bus of bin2bcd_seq; the master drives requests.
interface bin2bcd_seq_if #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
);
  import bin2bcd_pkg::*;

  logic                          start;
  logic [BIN_W-1:0]              bin;
  logic                          busy;
  logic                          done;
  logic [BCD_DIGIT_W*DIGITS-1:0] bcd;
  logic                          overflow;

  modport master (output start, output bin, input busy, input done, input bcd, input overflow);
  modport slave  (input start, input bin, output busy, output done, output bcd, output overflow);
endinterface

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: a digit of 5 or more gets 3 added before the shift.
module bcd_add3
  import bin2bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] i_d,
  output logic [BCD_DIGIT_W-1:0] o_d
);

  assign o_d = (i_d >= 4'd5) ? (i_d + 4'd3) : i_d;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one input bit per clock (shift-and-add-3).
// Define BIN2BCD_BLANK_EN to replace leading zero digits with the blank code.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic         clk,
  input  logic         rst,
  bin2bcd_seq_if.slave bus
);

  localparam int SCR_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  function automatic logic [SCR_W-1:0] fmt_bcd(input logic [SCR_W-1:0] v);
    logic [SCR_W-1:0] r;
`ifdef BIN2BCD_BLANK_EN
    logic lead;
    r    = v;
    lead = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (lead && (v[i*BCD_DIGIT_W +: BCD_DIGIT_W] == 4'h0)) begin
        r[i*BCD_DIGIT_W +: BCD_DIGIT_W] = BCD_BLANK;
      end else begin
        lead = 1'b0;
      end
    end
`else
    r = v;
`endif
    return r;
  endfunction

  localparam logic [SCR_W-1:0] BCD_RST = fmt_bcd({SCR_W{1'b0}});

  state_t               r_state;
  state_t               w_next_state;
  logic                 w_load;
  logic                 w_finish;
  logic [BIN_W-1:0]     r_shift;
  logic [SCR_W-1:0]     r_scratch;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_ovf;
  logic [SCR_W-1:0]     r_bcd;
  logic                 r_done;
  logic                 r_overflow;
  logic [SCR_W-1:0]     w_corr;
  logic [SCR_W+BIN_W:0] w_wide;
  logic [SCR_W-1:0]     w_new_scratch;
  logic                 w_ovf_next;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_add3 u_add3 (
      .i_d (r_scratch[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .o_d (w_corr[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // Top bit of the widened word is whatever falls out of the most significant digit.
  assign w_wide        = {w_corr, r_shift, 1'b0};
  assign w_new_scratch = w_wide[BIN_W +: SCR_W];
  assign w_ovf_next    = r_ovf | w_wide[SCR_W+BIN_W];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and control decode.
  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_next_state = SHIFT;
          w_load       = 1'b1;
        end else begin
          w_next_state = IDLE;
        end
      end
      SHIFT: begin
        if (r_cnt == CNT_W'(1)) begin
          w_next_state = IDLE;
          w_finish     = 1'b1;
        end else begin
          w_next_state = SHIFT;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Datapath: load, shift/correct, and capture the final value on completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift    <= {BIN_W{1'b0}};
      r_scratch  <= {SCR_W{1'b0}};
      r_cnt      <= {CNT_W{1'b0}};
      r_ovf      <= 1'b0;
      r_bcd      <= BCD_RST;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (w_load) begin
        r_shift   <= bus.bin;
        r_scratch <= {SCR_W{1'b0}};
        r_ovf     <= 1'b0;
        r_cnt     <= CNT_W'(BIN_W);
      end else if (r_state == SHIFT) begin
        r_shift   <= w_wide[BIN_W-1:0];
        r_scratch <= w_new_scratch;
        r_ovf     <= w_ovf_next;
        r_cnt     <= r_cnt - CNT_W'(1);
      end
      if (w_finish) begin
        r_bcd      <= fmt_bcd(w_new_scratch);
        r_overflow <= w_ovf_next;
      end
    end
  end

  assign bus.busy     = (r_state == SHIFT);
  assign bus.done     = r_done;
  assign bus.bcd      = r_bcd;
  assign bus.overflow = r_overflow;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: three configurations (8/3, 8/2, 1/1) share clock and reset.
module tb_bin2bcd_seq;

`ifdef BIN2BCD_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  typedef struct {
    logic [11:0] bcd;
    logic        ovf;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];
  exp_t ea, eb, ec;

  bin2bcd_seq_if #(.BIN_W(8), .DIGITS(3)) ifa ();
  bin2bcd_seq_if #(.BIN_W(8), .DIGITS(2)) ifb ();
  bin2bcd_seq_if #(.BIN_W(1), .DIGITS(1)) ifc ();

  bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) ua (.clk(clk), .rst(rst), .bus(ifa));
  bin2bcd_seq #(.BIN_W(8), .DIGITS(2)) ub (.clk(clk), .rst(rst), .bus(ifb));
  bin2bcd_seq #(.BIN_W(1), .DIGITS(1)) uc (.clk(clk), .rst(rst), .bus(ifc));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=done_pulse required=no_pulse", name);
  endtask

  // Monitors: pop and compare whenever a DUT signals done.
  always @(negedge clk) begin
    if (ifa.done) begin
      if (qa.size() == 0) unexpected("a_unexpected_done");
      else begin
        ea = qa.pop_front();
        chk("a_bcd", {20'd0, ifa.bcd}, {20'd0, ea.bcd});
        chk("a_ovf", {31'd0, ifa.overflow}, {31'd0, ea.ovf});
        chk("a_latency", cyc, ea.cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (ifb.done) begin
      if (qb.size() == 0) unexpected("b_unexpected_done");
      else begin
        eb = qb.pop_front();
        chk("b_bcd", {24'd0, ifb.bcd}, {20'd0, eb.bcd});
        chk("b_ovf", {31'd0, ifb.overflow}, {31'd0, eb.ovf});
        chk("b_latency", cyc, eb.cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (ifc.done) begin
      if (qc.size() == 0) unexpected("c_unexpected_done");
      else begin
        ec = qc.pop_front();
        chk("c_bcd", {28'd0, ifc.bcd}, {20'd0, ec.bcd});
        chk("c_ovf", {31'd0, ifc.overflow}, {31'd0, ec.ovf});
        chk("c_latency", cyc, ec.cyc);
      end
    end
  end

  // Stimulus tasks are entered on a falling edge and return on the next one.
  task automatic go_a(input logic [7:0] v, input logic [11:0] e, input logic o);
    exp_t x;
    x.bcd = e; x.ovf = o; x.cyc = cyc + 1 + 8;
    ifa.start = 1'b1; ifa.bin = v; qa.push_back(x);
    @(negedge clk);
    ifa.start = 1'b0;
  endtask

  task automatic go_b(input logic [7:0] v, input logic [7:0] e, input logic o);
    exp_t x;
    x.bcd = {4'h0, e}; x.ovf = o; x.cyc = cyc + 1 + 8;
    ifb.start = 1'b1; ifb.bin = v; qb.push_back(x);
    @(negedge clk);
    ifb.start = 1'b0;
  endtask

  task automatic go_c(input logic v, input logic [3:0] e);
    exp_t x;
    x.bcd = {8'h00, e}; x.ovf = 1'b0; x.cyc = cyc + 1 + 1;
    ifc.start = 1'b1; ifc.bin = v; qc.push_back(x);
    @(negedge clk);
    ifc.start = 1'b0;
  endtask

  // Directed vectors: {bin, expected unblanked, expected blanked, overflow}
  logic [7:0]  va_bin [5] = '{8'd0, 8'd255, 8'd42, 8'd100, 8'd5};
  logic [11:0] va_raw [5] = '{12'h000, 12'h255, 12'h042, 12'h100, 12'h005};
  logic [11:0] va_blk [5] = '{12'hFF0, 12'h255, 12'hF42, 12'h100, 12'hFF5};
  logic [7:0]  vb_bin [4] = '{8'd100, 8'd99, 8'd250, 8'd7};
  logic [7:0]  vb_raw [4] = '{8'h00, 8'h99, 8'h50, 8'h07};
  logic [7:0]  vb_blk [4] = '{8'hF0, 8'h99, 8'h50, 8'hF7};
  logic        vb_ovf [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

  logic [11:0] rst_a;
  logic [7:0]  rst_b;
  bit          found;

  initial begin
    ifa.start = 1'b0; ifa.bin = 8'd0;
    ifb.start = 1'b0; ifb.bin = 8'd0;
    ifc.start = 1'b0; ifc.bin = 1'b0;
    rst_a = BLANK ? 12'hFF0 : 12'h000;
    rst_b = BLANK ? 8'hF0 : 8'h00;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_a_bcd", {20'd0, ifa.bcd}, {20'd0, rst_a});
    chk("rst_a_busy", {31'd0, ifa.busy}, 32'd0);
    chk("rst_a_done", {31'd0, ifa.done}, 32'd0);
    chk("rst_a_ovf", {31'd0, ifa.overflow}, 32'd0);
    chk("rst_b_bcd", {24'd0, ifb.bcd}, {24'd0, rst_b});
    chk("rst_c_bcd", {28'd0, ifc.bcd}, 32'd0);

    for (int i = 0; i < 5; i++) begin
      go_a(va_bin[i], BLANK ? va_blk[i] : va_raw[i], 1'b0);
      repeat (10) @(negedge clk);
    end
    for (int i = 0; i < 4; i++) begin
      go_b(vb_bin[i], BLANK ? vb_blk[i] : vb_raw[i], vb_ovf[i]);
      repeat (10) @(negedge clk);
    end
    go_c(1'b1, 4'h1);
    repeat (2) @(negedge clk);
    go_c(1'b0, 4'h0);
    repeat (2) @(negedge clk);

    // Starts while busy must be dropped; a start in the done cycle must be taken.
    go_a(8'd7, BLANK ? 12'hFF7 : 12'h007, 1'b0);
    for (int i = 0; i < 4; i++) begin
      ifa.start = 1'b1; ifa.bin = 8'd99;
      chk("a_busy_during_conv", {31'd0, ifa.busy}, 32'd1);
      @(negedge clk);
    end
    ifa.start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (ifa.done) found = 1'b1;
      else @(negedge clk);
    end
    chk("a_first_done_seen", {31'd0, found}, 32'd1);
    go_a(8'd99, BLANK ? 12'hF99 : 12'h099, 1'b0);
    repeat (10) @(negedge clk);

    // Reset four cycles into a conversion: aborted, no done afterwards.
    ifa.start = 1'b1; ifa.bin = 8'd123;
    @(negedge clk);
    ifa.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_busy", {31'd0, ifa.busy}, 32'd0);
    chk("midrst_done", {31'd0, ifa.done}, 32'd0);
    chk("midrst_bcd", {20'd0, ifa.bcd}, {20'd0, rst_a});
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);

    for (int i = 0; i < 50 && (qa.size() + qb.size() + qc.size()) != 0; i++) @(negedge clk);
    chk("drain_a", qa.size(), 32'd0);
    chk("drain_b", qb.size(), 32'd0);
    chk("drain_c", qc.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
